// File: rtl/if_prefetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the instruction memory,
// buffers returned words in a small FIFO and hands them to decode over valid/ready.
module if_prefetch_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  output logic [31:0]                  im_addr,
  input  logic [31:0]                  im_inst,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_pc,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t         state_r;
  logic [31:0]    fetch_pc_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [PW-1:0]  wr_ptr_r;
  logic [CW-1:0]  count_r;
  logic           halted_r;
  logic [31:0]    mem_pc_r   [DEPTH];
  logic [31:0]    mem_inst_r [DEPTH];

  logic           pop_s;
  logic           push_s;
  logic           not_empty_s;

  // Handshake decode: pop on accepted head, push while fetching with room (or room made by a pop).
  always_comb begin
    not_empty_s = (count_r != CNT_ZERO);
    pop_s       = not_empty_s && out_ready;
    push_s      = 1'b0;
    if ((state_r == FETCH) && en) begin
      push_s = (count_r < CNT_FULL) || pop_s;
    end else begin
      push_s = 1'b0;
    end
  end

  // Head presentation; an empty FIFO shows a harmless NOP at address zero.
  always_comb begin
    out_valid = not_empty_s;
    if (not_empty_s) begin
      out_inst = mem_inst_r[rd_ptr_r];
      out_pc   = mem_pc_r[rd_ptr_r];
    end else begin
      out_inst = NOP_INST;
      out_pc   = 32'h0000_0000;
    end
  end

  assign im_addr    = {fetch_pc_r[31:2], 2'b00};
  assign halted     = halted_r;
  assign fifo_count = count_r;

  // Fetch sequencer, FIFO storage and pointers; redirect overrides any push/pop in its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= CNT_ZERO;
      halted_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_r[i]   <= 32'h0000_0000;
        mem_inst_r[i] <= 32'h0000_0000;
      end
    end else if (redirect_valid) begin
      fetch_pc_r <= {redirect_pc[31:2], 2'b00};
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= CNT_ZERO;
      halted_r   <= 1'b0;
      state_r    <= en ? FETCH : IDLE;
    end else begin
      if (push_s) begin
        mem_pc_r[wr_ptr_r]   <= im_addr;
        mem_inst_r[wr_ptr_r] <= im_inst;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
        fetch_pc_r           <= im_addr + 32'd4;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      case (state_r)
        IDLE: begin
          if (en) begin
            state_r <= FETCH;
          end
        end
        FETCH: begin
          if (push_s && (im_inst == EBREAK_INST)) begin
            state_r  <= HALTED;
            halted_r <= 1'b1;
          end else if (!en) begin
            state_r <= IDLE;
          end
        end
        HALTED: begin
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= IDLE;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
